imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//   Controller and arbiter for the single-port 256-word instruction memory.
//   After reset it runs a LOAD phase: program words are written in from a loader port while the CPU fetch stage is stalled.
//   In the RUN phase it shares the read port between CPU fetch and a debug read port, using round-robin arbitration.
//   It sits between the fetch stage / debug unit and the instruction RAM, which has a 1-cycle synchronous read.
// PARAMETERS
//   DEPTH   256  memory depth in words; index = address[AW+1:2]
//   AW      8    word-index width, clog2(DEPTH)
// PORTS
//   clk         in   1   clock; all state updates on the rising edge
//   rst         in   1   synchronous, active-high reset
//   ld_valid    in   1   loader word valid
//   ld_ready    out  1   loader word accepted (high only in LOAD)
//   ld_addr     in   AW  loader word index
//   ld_data     in   32  loader word
//   ld_last     in   1   final word of the image, qualified by ld_valid
//   reload      in   1   one-cycle pulse: return to LOAD
//   cpu_req     in   1   fetch request
//   cpu_addr    in   32  fetch byte address
//   cpu_gnt     out  1   fetch request accepted this cycle
//   cpu_stall   out  1   cpu_req & ~cpu_gnt, or state != RUN
//   cpu_rvalid  out  1   fetch data valid (one cycle after cpu_gnt)
//   cpu_rdata   out  32  fetch data
//   cpu_err     out  1   misaligned fetch; asserted together with cpu_rvalid
//   dbg_req     in   1   debug read request
//   dbg_addr    in   AW  debug word index
//   dbg_gnt     out  1   debug request accepted this cycle
//   dbg_rvalid  out  1   debug data valid (one cycle after dbg_gnt)
//   dbg_rdata   out  32  debug data
//   mem_we      out  1   RAM write enable
//   mem_addr    out  AW  RAM word index
//   mem_wdata   out  32  RAM write data
//   mem_rdata   in   32  RAM read data, valid the cycle after mem_addr
//   load_cnt    out  AW+1  words accepted in the current LOAD phase
//   running     out  1   state == RUN
// BEHAVIOUR
//   Reset: state=LOAD, load_cnt=0, rr pointer=CPU.
//     All outputs 0 except cpu_stall=1 and ld_ready=1.
//   States: LOAD, RUN.
//     LOAD->RUN: accepted word with ld_last=1, or load_cnt reaching DEPTH; RUN is entered the next cycle.
//     RUN->LOAD: reload=1; takes effect the next cycle and clears load_cnt.
//   LOAD phase
//     - ld_ready=1; handshake is ld_valid & ld_ready.
//     - On a handshake: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle; load_cnt increments.
//     - No grants; cpu_stall=1; cpu_req and dbg_req are ignored.
//     - reload in LOAD has no effect.
//   RUN phase
//     - ld_ready=0 and ld_valid is ignored. mem_we is never asserted.
//     - Grant is combinational in the same cycle. At most one grant per cycle.
//     - Single requester: it is granted.
//     - Both requesting: the requester not granted last time wins (rr pointer). The pointer updates only on a contested grant.
//     - Granted CPU: mem_addr = cpu_addr[AW+1:2]; upper address bits are ignored (wrap).
//     - Granted debug: mem_addr = dbg_addr.
//     - rvalid is asserted one cycle after the grant, with rdata = mem_rdata. rdata holds its last value otherwise.
//     - cpu_addr[1:0] != 0 when granted: cpu_rvalid=1 and cpu_err=1 next cycle, cpu_rdata=0.
//   Simultaneous events
//     - reload with requests: no grant that cycle.
//     - A read granted the previous cycle still returns its rvalid.
//   Mid-operation rst
//     - Pending rvalids are dropped (0 next cycle) and the state returns to LOAD.
//     - Memory contents are not cleared.
// TESTING
//   1. rst, load words 0..3 = 0x00000037, 0x000000b7, 0x02002103, 0x000001B7, last on idx 3
//      -> load_cnt=4, running=1 the next cycle, cpu_stall=1 throughout LOAD.
//   2. RUN, cpu_req with cpu_addr=0x8
//      -> cpu_gnt same cycle; cpu_rvalid next cycle with cpu_rdata=0x02002103.
//   3. cpu_req and dbg_req held together for 4 cycles
//      -> grants alternate CPU, DBG, CPU, DBG; never both high in one cycle.
//   4. cpu_addr=0x6 granted
//      -> next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
//      Also: cpu_addr=0x404 -> reads word 1 (wrap).
//   5. reload pulse with cpu_req high
//      -> no grant; next cycle running=0, ld_ready=1, load_cnt=0.
//   6. Load DEPTH words without ld_last -> auto RUN after the 256th word.
//      Also: rst asserted one cycle after a grant -> no rvalid, state LOAD.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory controller: loads the program image after reset, then shares
// the single RAM read port between CPU fetch and debug reads with round-robin arbitration.
module imem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          reload,
  input  logic          cpu_req,
  input  logic [31:0]   cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   load_cnt,
  output logic          running
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_t        state_r;
  logic [AW:0]   load_cnt_r;
  logic          rr_dbg_r;      // set when debug wins the next contested cycle
  logic          cpu_pend_r;
  logic          cpu_mis_r;
  logic          dbg_pend_r;
  logic [31:0]   cpu_hold_r;
  logic [31:0]   dbg_hold_r;

  logic          run_s;
  logic          hs_s;
  logic          load_done_s;
  logic          cpu_gnt_s;
  logic          dbg_gnt_s;
  logic          cpu_rv_s;
  logic          dbg_rv_s;
  logic [31:0]   cpu_data_s;
  logic [31:0]   dbg_data_s;
  logic [AW-1:0] mem_addr_s;
  logic          unused_addr_s;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[AW+1:2];
  endfunction

  assign unused_addr_s = ^cpu_addr[31:AW+2];

  // Load handshake, round-robin grant, RAM port mux and read-return data path
  always_comb begin
    run_s       = (state_r == RUN);
    hs_s        = ~run_s & ld_valid;
    load_done_s = hs_s & (ld_last | (load_cnt_r == LAST_CNT));
    cpu_gnt_s   = 1'b0;
    dbg_gnt_s   = 1'b0;
    if (run_s && !reload) begin
      cpu_gnt_s = cpu_req & (~dbg_req | ~rr_dbg_r);
      dbg_gnt_s = dbg_req & (~cpu_req | rr_dbg_r);
    end else begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end
    mem_addr_s = {AW{1'b0}};
    if (cpu_gnt_s) begin
      mem_addr_s = word_idx(cpu_addr);
    end else if (dbg_gnt_s) begin
      mem_addr_s = dbg_addr;
    end else if (hs_s) begin
      mem_addr_s = ld_addr;
    end else begin
      mem_addr_s = {AW{1'b0}};
    end
    // a read return is dropped in the very cycle reset is applied
    cpu_rv_s   = cpu_pend_r & ~rst;
    dbg_rv_s   = dbg_pend_r & ~rst;
    cpu_data_s = cpu_hold_r;
    if (cpu_rv_s) begin
      cpu_data_s = cpu_mis_r ? 32'h0000_0000 : mem_rdata;
    end else begin
      cpu_data_s = cpu_hold_r;
    end
    dbg_data_s = dbg_hold_r;
    if (dbg_rv_s) begin
      dbg_data_s = mem_rdata;
    end else begin
      dbg_data_s = dbg_hold_r;
    end
  end

  // Phase FSM, load counter, arbitration pointer and read-return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= LOAD;
      load_cnt_r <= {(AW+1){1'b0}};
      rr_dbg_r   <= 1'b0;
      cpu_pend_r <= 1'b0;
      cpu_mis_r  <= 1'b0;
      dbg_pend_r <= 1'b0;
      cpu_hold_r <= 32'h0000_0000;
      dbg_hold_r <= 32'h0000_0000;
    end else begin
      cpu_pend_r <= cpu_gnt_s;
      cpu_mis_r  <= cpu_gnt_s & (cpu_addr[1:0] != 2'b00);
      dbg_pend_r <= dbg_gnt_s;
      if (cpu_rv_s) cpu_hold_r <= cpu_data_s;
      if (dbg_rv_s) dbg_hold_r <= dbg_data_s;
      case (state_r)
        LOAD: begin
          if (hs_s) begin
            load_cnt_r <= load_cnt_r + CNT_ONE;
            if (load_done_s) state_r <= RUN;
          end
        end
        RUN: begin
          if (reload) begin
            state_r    <= LOAD;
            load_cnt_r <= {(AW+1){1'b0}};
          end else if (cpu_req && dbg_req) begin
            rr_dbg_r <= cpu_gnt_s;
          end
        end
        default: state_r <= LOAD;
      endcase
    end
  end

  assign ld_ready   = ~run_s;
  assign running    = run_s;
  assign load_cnt   = load_cnt_r;
  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign cpu_stall  = ~run_s | (cpu_req & ~cpu_gnt_s);
  assign cpu_rvalid = cpu_rv_s;
  assign cpu_err    = cpu_rv_s & cpu_mis_r;
  assign cpu_rdata  = cpu_data_s;
  assign dbg_rvalid = dbg_rv_s;
  assign dbg_rdata  = dbg_data_s;
  assign mem_we     = hs_s;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = hs_s ? ld_data : 32'h0000_0000;

endmodule
